dot_product_mac: RTL

- Sequential, parametrised multiply-accumulate engine for the SPU datapath.
- Streams up to MAX_LEN operand pairs (a,b) over a valid/ready handshake and accumulates sum(a*b) onto a preloaded accumulator.
- Presents the result on a valid/ready output port.
- Generalises the single-step combinational dot-product op in four ways: configurable operand width, vector length, signedness and overflow mode, plus a sticky overflow flag.

---
 rtl/tinyspu_pkg.sv | 17 +
 rtl/mac_sat.sv | 45 ++++
 rtl/dot_product_mac.sv | 96 +++++++++
 3 files changed

// File: rtl/tinyspu_pkg.sv
// Shared SPU definitions: controller state encoding and default datapath widths.
package tinyspu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } mac_state_t;

endpackage

// File: rtl/mac_sat.sv
// One multiply-accumulate step with wrap or saturate on out-of-range sums.
module mac_sat #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 11,
    parameter int SIGNED = 0
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sat_en,
    output logic [ACC_W-1:0]  next_acc,
    output logic              ovf
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_prod_x;
    logic [ACC_W:0]      w_acc_x;
    logic [ACC_W:0]      w_sum;
    logic [ACC_W-1:0]    w_clamp;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DATA_W-1:0] w_prod_s;
            assign w_prod_s = $signed(a) * $signed(b);
            assign w_prod   = w_prod_s;
            assign w_prod_x = {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
            assign w_acc_x  = {acc[ACC_W-1], acc};
            // Top two bits disagree when the true sum left the ACC_W range; bit ACC_W is the true sign.
            assign ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            assign w_clamp  = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin : g_unsigned
            assign w_prod   = a * b;
            assign w_prod_x = {{(ACC_W+1-2*DATA_W){1'b0}}, w_prod};
            assign w_acc_x  = {1'b0, acc};
            // Only non-negative products are added, so the sole escape is past the top.
            assign ovf      = w_sum[ACC_W];
            assign w_clamp  = {ACC_W{1'b1}};
        end
    endgenerate

    assign w_sum    = w_acc_x + w_prod_x;
    assign next_acc = (ovf && sat_en) ? w_clamp : w_sum[ACC_W-1:0];

endmodule

// File: rtl/dot_product_mac.sv
// Streaming dot-product engine: preload, accumulate len operand pairs, hand off result.
module dot_product_mac
    import tinyspu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = 8,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SIGNED  = 0,
    parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  acc_init,
    input  logic              sat_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy
);

    mac_state_t       r_state;
    mac_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_ovf;

    logic [LEN_W-1:0] w_len_clamp;
    logic [ACC_W-1:0] w_next_acc;
    logic             w_step_ovf;
    logic             w_accept;
    logic             w_start_acc;

    assign w_len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign w_accept    = in_valid && (r_state == S_RUN);
    assign w_start_acc = start && (r_state == S_IDLE);

    mac_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac_sat (
        .acc      (r_acc),
        .a        (a),
        .b        (b),
        .sat_en   (r_mode),
        .next_acc (w_next_acc),
        .ovf      (w_step_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_accept && r_cnt == LEN_W'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_acc  <= acc_init;
                r_cnt  <= w_len_clamp;
                r_mode <= sat_en;
                r_ovf  <= 1'b0;
            end else if (w_accept) begin
                r_acc <= w_next_acc;
                r_cnt <= r_cnt - LEN_W'(1);
                if (w_step_ovf) r_ovf <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_acc;
    assign overflow  = r_ovf;

endmodule
